sync_frame_tx: RTL and testbench
================================

# sync_frame_tx

Serial frame transmitter sitting directly upstream of the `1000001` overlapping sequence detector. It accepts a parallel data word over a valid/ready handshake and emits it one bit per clock on a serial line. Each word is preceded by the 7-bit sync pattern `1000001`, and the payload is zero-bit-stuffed so the detector sees exactly one match per frame. The line idles high.

## Interface
Parameters:
- `DATA_W`, default 8: payload width; bits are sent MSB first.
- `SYNC`, default 7'b1000001: sync pattern; MSB is sent first.
- `SYNC_W`, default 7: sync pattern width.
- `STUFF_RUN`, default 4: number of consecutive payload zeros after which a `1` is inserted.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: **asynchronous, active-low** reset (asserted at 0).
- `in_data` input DATA_W: word to transmit; sampled only on handshake.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a word.
- `out` output 1: registered serial bit, connects to the detector `in`.
- `frame_start` output 1: registered; high during the cycle the first sync bit is on `out`.
- `busy` output 1: high while in any state other than IDLE.

## Operation
The block is a four-state machine: IDLE, SYNC, DATA, STUFF. Internal registers are a shift register `shreg[DATA_W]`, bit index `idx`, and zero-run counter `zrun` (width clog2(STUFF_RUN+1)).

- **IDLE**
  - `out`=1; `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_data` into `shreg`, set `idx`=0, go to SYNC.
- **SYNC**
  - `out`=SYNC[SYNC_W-1-idx].
  - After SYNC_W bits: go to DATA with `idx`=0, `zrun`=0.
- **DATA**
  - `out`=`shreg` MSB, then shift left and increment `idx`.
  - A 0 bit increments `zrun`; a 1 bit clears it.
  - If this bit made `zrun`==STUFF_RUN, go to STUFF. This applies even when it is the last bit.
  - Otherwise, after DATA_W bits, go to IDLE.
- **STUFF**
  - `out`=1; clear `zrun`.
  - Return to DATA if bits remain, else go to IDLE.

Rules and boundary conditions:
- `in_ready` = (state==IDLE) and `reset` deasserted. A word is never accepted mid-frame.
- `in_valid` asserted while busy is ignored. The upstream must hold its word until the handshake.
- Consecutive frames are separated by at least one IDLE cycle (`out`=1).
- The payload never contains STUFF_RUN+1 consecutive zeros, so SYNC can never appear inside a payload. The sync ends in `1`, so the zero run starts at 0.
- Frame length in bits = SYNC_W + DATA_W + number of stuffed bits. With the defaults this is 15 to 17 bits.
- Reset is asynchronous and may be asserted mid-frame. The current frame is abandoned and the latched word is discarded.
- Reset values: state=IDLE, `out`=1, `frame_start`=0, `busy`=0, `in_ready`=0 while reset is held, `shreg`/`idx`/`zrun`=0.

## Timing
- Handshake at rising edge k: `out` carries SYNC bit 0 and `frame_start`=1 from edge k to edge k+1. This is a latency of 1 cycle.
- The last payload bit (or trailing stuff bit) is on `out` during cycle k+SYNC_W+DATA_W+stuffs-1. IDLE follows on the next cycle.
- `in_ready` rises one cycle after the last frame bit. The earliest next handshake falls on that cycle's closing edge.
- All outputs except `in_ready` are registered. `in_ready` is a decode of the state register.
- Reset release: the first accept is possible at the first rising edge after `reset` goes high.

## Structure
- Shared package holds:
  - the state enum (IDLE, SYNC, DATA, STUFF);
  - SYNC pattern constant 7'b1000001 with SYNC_W=7, so the detector and transmitter share one definition;
  - STUFF_RUN default.
- Single module; no sub-module needed. The zero-run counter and stuff decision stay inline.
- The bench instantiates the existing detector downstream as the checker.

## Test plan
- Send 0xA5 → `out` = 1000001 10100101 (15 bits, no stuffing). The detector `out` pulses exactly once, after the 7th bit.
- Send 0x00 → `out` = 1000001 0000 1 0000 1 (17 bits). `busy` stays high for 17 cycles. The detector pulses once.
- Send 0x80 → `out` = 1000001 1 0000 1 000 (16 bits). No detector pulse within the payload.
- Hold `in_valid`=1 with words 0x3C then 0xFF → frames are separated by exactly one idle `1`. `frame_start` pulses twice, and each word is transmitted unchanged.
- Assert `reset`=0 mid-DATA of a 0x55 frame → `out`=1 and `busy`=0 immediately. After release, a new 0x0F frame is sent cleanly with no residue of 0x55.
- Toggle `in_data`/`in_valid` while busy → no effect on the frame in flight, and `in_ready` stays 0 until IDLE.

Source files
------------

// File: rtl/sync_frame_tx_pkg.sv
// sync_frame_tx_pkg: shared FSM states and the sync pattern.
// The downstream 1000001 detector uses the same definitions.
package sync_frame_tx_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_STUFF} state_t;
   localparam int SYNC_W_DEF = 7;
   localparam logic [SYNC_W_DEF-1:0] SYNC_PAT = 7'b1000001;
   localparam int STUFF_RUN_DEF = 4;
endpackage

// File: rtl/sync_frame_tx_if.sv
// sync_frame_tx_if: word handshake plus serial line and status outputs.
interface sync_frame_tx_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic out;
   logic frame_start;
   logic busy;
   modport master (output in_data, in_valid, input in_ready, out, frame_start, busy);
   modport slave (input in_data, in_valid, output in_ready, out, frame_start, busy);
endinterface

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: sends each accepted word MSB first behind a sync pattern, zero-bit-stuffed.
// The line idles high; out is registered and carries one bit per clock.
module sync_frame_tx
   import sync_frame_tx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SYNC_W = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC = SYNC_PAT,
   parameter int STUFF_RUN = STUFF_RUN_DEF
) (
   input logic clk,
   input logic reset,
   sync_frame_tx_if.slave bus
);
   localparam int IDX_W = $clog2((DATA_W > SYNC_W ? DATA_W : SYNC_W) + 1);
   localparam int ZRUN_W = $clog2(STUFF_RUN + 1);
   state_t r_state, w_state;
   logic [DATA_W-1:0] r_shreg, w_shreg;
   logic [IDX_W-1:0] r_idx, w_idx;
   logic [ZRUN_W-1:0] r_zrun, w_zrun, w_zinc;
   logic [SYNC_W-1:0] w_sync_sh;
   logic r_out, r_frame_start, w_out, w_accept;
   assign bus.in_ready = (r_state == ST_IDLE) && reset;
   assign bus.out = r_out;
   assign bus.frame_start = r_frame_start;
   assign bus.busy = r_state != ST_IDLE;
   assign w_accept = bus.in_ready && bus.in_valid;
   // zero-run count including the payload bit currently on the line
   assign w_zinc = r_shreg[DATA_W-1] ? '0 : r_zrun + 1'b1;
   always_comb begin
      w_state = r_state;
      w_shreg = r_shreg;
      w_idx = r_idx;
      w_zrun = r_zrun;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state = ST_SYNC;
               w_shreg = bus.in_data;
               w_idx = '0;
            end
         end
         ST_SYNC: begin
            w_idx = r_idx + 1'b1;
            if (r_idx == IDX_W'(SYNC_W - 1)) begin
               w_state = ST_DATA;
               w_idx = '0;
               w_zrun = '0;
            end
         end
         ST_DATA: begin
            w_shreg = r_shreg << 1;
            w_idx = r_idx + 1'b1;
            w_zrun = w_zinc;
            w_state = (w_zinc == ZRUN_W'(STUFF_RUN)) ? ST_STUFF :
                      (r_idx == IDX_W'(DATA_W - 1)) ? ST_IDLE : ST_DATA;
         end
         default: begin
            w_zrun = '0;
            w_state = (r_idx == IDX_W'(DATA_W)) ? ST_IDLE : ST_DATA;
         end
      endcase
   end
   // the registered line bit belongs to the state entered at this edge
   assign w_sync_sh = SYNC << w_idx;
   assign w_out = (w_state == ST_SYNC) ? w_sync_sh[SYNC_W-1] :
                  (w_state == ST_DATA) ? w_shreg[DATA_W-1] : 1'b1;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_idx <= '0;
         r_zrun <= '0;
         r_out <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_state <= w_state;
         r_shreg <= w_shreg;
         r_idx <= w_idx;
         r_zrun <= w_zrun;
         r_out <= w_out;
         r_frame_start <= w_accept;
      end
   end
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: directed frames checked against hand-derived bit strings.
// A 1000001 match counter over the captured line stands in for the detector.
module tb_sync_frame_tx;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   sync_frame_tx_if #(.DATA_W(8)) bif ();
   sync_frame_tx dut (.clk(clk), .reset(reset), .bus(bif));

   task automatic start(input logic [7:0] d, input bit drop);
      int n = 0;
      @(negedge clk);
      while (!bif.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!bif.in_ready) begin
         bad++;
         $display("FAIL start_ready got=%0b want=1", bif.in_ready);
      end
      bif.in_data = d;
      bif.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (drop) bif.in_valid = 1'b0;
   endtask

   task automatic capture(input bit tog, output logic [31:0] bits, output int nb, output int nfs,
                          output int fpos, output int ndet, output int dpos, output int nrdy);
      logic [6:0] h = '1;
      bits = '0; nb = 0; nfs = 0; fpos = 0; ndet = 0; dpos = 0; nrdy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bif.busy) break;
         bits = {bits[30:0], bif.out};
         h = {h[5:0], bif.out};
         nb++;
         if (bif.frame_start) begin
            nfs++;
            fpos = nb;
         end
         if (h == 7'b1000001) begin
            ndet++;
            dpos = nb;
         end
         if (bif.in_ready) nrdy++;
         if (tog) begin
            bif.in_data = 8'($urandom);
            bif.in_valid = 1'($urandom_range(0, 1));
         end
      end
      if (tog) bif.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total += 4;
      if (bif.out !== 1'b1) begin bad++; $display("FAIL rst_out got=%b want=1", bif.out); end
      if (bif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bif.busy); end
      if (bif.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bif.in_ready); end
      if (bif.frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", bif.frame_start); end
      reset = 1'b1;
      #1;
      total++;
      if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b want=1", bif.in_ready); end
   endtask

   task automatic test_frame(input string name, input logic [7:0] d, input logic [31:0] exp, input int n);
      logic [31:0] bits;
      int nb, nfs, fpos, ndet, dpos, nrdy;
      start(d, 1'b1);
      capture(1'b0, bits, nb, nfs, fpos, ndet, dpos, nrdy);
      total += 6;
      if (bits !== exp) begin bad++; $display("FAIL %s_bits got=%h want=%h", name, bits, exp); end
      if (nb != n) begin bad++; $display("FAIL %s_len got=%0d want=%0d", name, nb, n); end
      if (nfs != 1 || fpos != 1) begin bad++; $display("FAIL %s_fs got=%0d@%0d want=1@1", name, nfs, fpos); end
      if (ndet != 1 || dpos != 7) begin bad++; $display("FAIL %s_det got=%0d@%0d want=1@7", name, ndet, dpos); end
      if (bif.out !== 1'b1) begin bad++; $display("FAIL %s_idle_out got=%b want=1", name, bif.out); end
      if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL %s_idle_ready got=%b want=1", name, bif.in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] b1, b2;
      int n1, f1, p1, d1, q1, r1, n2, f2, p2, d2, q2, r2;
      start(8'h3C, 1'b0);
      bif.in_data = 8'hFF;
      capture(1'b0, b1, n1, f1, p1, d1, q1, r1);
      total++;
      if (bif.out !== 1'b1) begin bad++; $display("FAIL b2b_gap got=%b want=1", bif.out); end
      @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
      capture(1'b0, b2, n2, f2, p2, d2, q2, r2);
      total += 4;
      if (b1 !== 32'b100000100111100) begin bad++; $display("FAIL b2b_w1 got=%h want=%h", b1, 32'b100000100111100); end
      if (b2 !== 32'b100000111111111) begin bad++; $display("FAIL b2b_w2 got=%h want=%h", b2, 32'b100000111111111); end
      if (n1 != 15 || n2 != 15) begin bad++; $display("FAIL b2b_len got=%0d,%0d want=15,15", n1, n2); end
      if (f1 + f2 != 2) begin bad++; $display("FAIL b2b_fs got=%0d want=2", f1 + f2); end
   endtask

   task automatic test_reset_mid();
      start(8'h55, 1'b1);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      total += 3;
      if (bif.out !== 1'b1) begin bad++; $display("FAIL mid_out got=%b want=1", bif.out); end
      if (bif.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bif.busy); end
      if (bif.in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", bif.in_ready); end
      @(negedge clk);
      reset = 1'b1;
      test_frame("post_rst", 8'h0F, 32'b1000001000011111, 16);
   endtask

   task automatic test_busy_inputs();
      logic [31:0] bits;
      int nb, nfs, fpos, ndet, dpos, nrdy;
      start(8'h96, 1'b1);
      capture(1'b1, bits, nb, nfs, fpos, ndet, dpos, nrdy);
      total += 3;
      if (bits !== 32'b100000110010110) begin bad++; $display("FAIL tog_bits got=%h want=%h", bits, 32'b100000110010110); end
      if (nrdy != 0) begin bad++; $display("FAIL tog_ready got=%0d want=0", nrdy); end
      if (nb != 15) begin bad++; $display("FAIL tog_len got=%0d want=15", nb); end
   endtask

   initial begin
      bif.in_data = '0;
      bif.in_valid = 1'b0;
      test_reset();
      test_frame("a5", 8'hA5, 32'b100000110100101, 15);
      test_frame("zero", 8'h00, 32'b10000010000100001, 17);
      test_frame("x80", 8'h80, 32'b1000001100001000, 16);
      test_back_to_back();
      test_reset_mid();
      test_busy_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
